// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer port arbiter.
// The optional write-stall counter is enabled with FB_ARB_STATS_EN.
package fb_pkg;

  localparam int ADDR_W       = 19;
  localparam int DATA_W       = 8;
  localparam int FRAME_PIXELS = 250000;

  typedef enum logic {
    FILL = 1'b0,
    PEND = 1'b1
  } bank_state_e;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_PROC = 2'd2
  } rd_tag_e;

  // oor marks a granted read that never reached the BRAM and must return 0
  typedef struct packed {
    rd_tag_e tag;
    logic    oor;
  } rd_tag_t;

  function automatic logic [ADDR_W-1:0] bank_base(input logic bank);
    return bank ? ADDR_W'(FRAME_PIXELS) : '0;
  endfunction

  function automatic logic in_frame(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(FRAME_PIXELS);
  endfunction

endpackage

// File: rtl/fb_rd_return.sv
// Read-return path: tags follow each granted read through the BRAM latency
// and steer the sampled data into the display or pipeline output register.
module fb_rd_return
  import fb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  rd_tag_t           tag_i,
  input  logic [DATA_W-1:0] bram_dout_i,
  output logic [DATA_W-1:0] disp_data_o,
  output logic              disp_valid_o,
  output logic [DATA_W-1:0] proc_data_o,
  output logic              proc_valid_o
);

  rd_tag_t           tag_q [RD_LAT+1];
  rd_tag_t           ret_tag;
  logic [DATA_W-1:0] ret_data;
  logic [DATA_W-1:0] disp_data_q;
  logic              disp_valid_q;
  logic [DATA_W-1:0] proc_data_q;
  logic              proc_valid_q;

  // Stage 0 loads alongside the bram_* registers; stage RD_LAT lines up with bram_dout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= RD_LAT; i++) begin
        tag_q[i] <= '{tag: TAG_NONE, oor: 1'b0};
      end
    end else begin
      tag_q[0] <= tag_i;
      for (int i = 1; i <= RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign ret_tag  = tag_q[RD_LAT];
  assign ret_data = ret_tag.oor ? '0 : bram_dout_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      proc_data_q  <= '0;
      proc_valid_q <= 1'b0;
    end else begin
      disp_valid_q <= (ret_tag.tag == TAG_DISP);
      proc_valid_q <= (ret_tag.tag == TAG_PROC);
      if (ret_tag.tag == TAG_DISP) disp_data_q <= ret_data;
      if (ret_tag.tag == TAG_PROC) proc_data_q <= ret_data;
    end
  end

  assign disp_data_o  = disp_data_q;
  assign disp_valid_o = disp_valid_q;
  assign proc_data_o  = proc_data_q;
  assign proc_valid_o = proc_valid_q;

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter with double buffering: display reads the front
// bank, the edge pipeline reads/writes the back bank. Optional FB_ARB_STATS_EN.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              frame_start,
  input  logic              proc_rd_req,
  input  logic [ADDR_W-1:0] proc_rd_addr,
  output logic              proc_rd_gnt,
  output logic [DATA_W-1:0] proc_rd_data,
  output logic              proc_rd_valid,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              wr_frame_done,
  output logic              ready,
  output logic              front_bank,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout
`ifdef FB_ARB_STATS_EN
  ,
  output logic [15:0]       wr_stall_cnt
`endif
);

  // Handshakes: a write transfers in a cycle where wr_valid & wr_ready; a pipeline
  // read transfers where proc_rd_gnt; display reads always transfer. Neither ready
  // nor gnt waits on anything but the current inputs and registered state.

  bank_state_e       state_q, state_d;
  logic              front_q;
  logic              swap;
  logic              fill;
  logic              ptr_q, ptr_d;   // 0: proc read has the next turn, 1: write
  logic              low_ok;
  logic              proc_gnt;
  logic              wr_rdy;
  logic              wr_acc;

  logic              bram_en_q, bram_we_q;
  logic [ADDR_W-1:0] bram_addr_q;
  logic [DATA_W-1:0] bram_din_q;

  logic              sel_en, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;
  rd_tag_t           sel_tag;

  logic [ADDR_W-1:0] disp_phys, proc_phys, wr_phys;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (wr_frame_done) state_d = PEND;
      PEND:    if (frame_start)   state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    fill = (state_q == FILL);
    swap = (state_q == PEND) & frame_start;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front_q <= 1'b0;
      ptr_q   <= 1'b0;
    end else begin
      front_q <= front_q ^ swap;
      ptr_q   <= ptr_d;
    end
  end

  assign ready      = fill;
  assign front_bank = front_q;

  // Display always wins; the two back-bank users share what is left in FILL.
  assign low_ok   = ~disp_req & fill;
  assign proc_gnt = low_ok & proc_rd_req & (~wr_valid | ~ptr_q);
  assign wr_rdy   = low_ok & (~proc_rd_req | ptr_q);
  assign wr_acc   = wr_valid & wr_rdy;

  always_comb begin
    ptr_d = ptr_q;
    if (proc_gnt)    ptr_d = 1'b1;
    else if (wr_acc) ptr_d = 1'b0;
  end

  assign proc_rd_gnt = proc_gnt;
  assign wr_ready    = wr_rdy;

  assign disp_phys = bank_base(front_q)  + disp_addr;
  assign proc_phys = bank_base(~front_q) + proc_rd_addr;
  assign wr_phys   = bank_base(~front_q) + wr_addr;

  // Out-of-range accesses leave the BRAM idle; reads still carry a tag so they return 0.
  always_comb begin
    sel_en   = 1'b0;
    sel_we   = 1'b0;
    sel_addr = bram_addr_q;
    sel_din  = bram_din_q;
    sel_tag  = '{tag: TAG_NONE, oor: 1'b0};
    if (disp_req) begin
      sel_tag = '{tag: TAG_DISP, oor: ~in_frame(disp_addr)};
      if (in_frame(disp_addr)) begin
        sel_en   = 1'b1;
        sel_addr = disp_phys;
      end
    end else if (proc_gnt) begin
      sel_tag = '{tag: TAG_PROC, oor: ~in_frame(proc_rd_addr)};
      if (in_frame(proc_rd_addr)) begin
        sel_en   = 1'b1;
        sel_addr = proc_phys;
      end
    end else if (wr_acc) begin
      if (in_frame(wr_addr)) begin
        sel_en   = 1'b1;
        sel_we   = 1'b1;
        sel_addr = wr_phys;
        sel_din  = wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bram_en_q   <= 1'b0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
    end else begin
      bram_en_q   <= sel_en;
      bram_we_q   <= sel_we;
      bram_addr_q <= sel_addr;
      bram_din_q  <= sel_din;
    end
  end

  assign bram_en   = bram_en_q;
  assign bram_we   = bram_we_q;
  assign bram_addr = bram_addr_q;
  assign bram_din  = bram_din_q;

  fb_rd_return #(
    .RD_LAT(RD_LAT)
  ) u_rd_return (
    .clk          (clk),
    .rst          (rst),
    .tag_i        (sel_tag),
    .bram_dout_i  (bram_dout),
    .disp_data_o  (disp_data),
    .disp_valid_o (disp_valid),
    .proc_data_o  (proc_rd_data),
    .proc_valid_o (proc_rd_valid)
  );

`ifdef FB_ARB_STATS_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (swap) begin
      stall_cnt_q <= '0;
    end else if (wr_valid && !wr_rdy && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign wr_stall_cnt = stall_cnt_q;
`endif

endmodule
